// File: rtl/img_frame_sequencer.sv
// Frame sequencer for the UART image pipeline: collects one frame of raw
// pixels into the source RAM, hands the frame to the blur filter, streams
// the filtered result back out over the UART, then re-arms for the next frame.
`timescale 1ns/1ps
module img_frame_sequencer #(
  parameter int PIXELS = 10000,
  parameter int AW     = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  // UART receiver
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  // raw-image RAM port
  output logic [AW-1:0] src_addr,
  output logic          src_we,
  output logic [7:0]    src_wdata,
  // blur filter
  input  logic [AW-1:0] flt_rd_addr,
  input  logic [AW-1:0] flt_wr_addr,
  input  logic          flt_wr_en,
  input  logic [7:0]    flt_wr_data,
  input  logic          flt_done,
  output logic          collect_finish,
  output logic          flt_clear,
  // result RAM port (read latency 1)
  output logic [AW-1:0] dst_addr,
  output logic          dst_we,
  output logic [7:0]    dst_wdata,
  input  logic [7:0]    dst_rdata,
  // UART transmitter
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  // status
  output logic [1:0]    phase,
  output logic          frame_done,
  output logic          rx_overrun
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PROCESS = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } send_t;

  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

  phase_t        st;
  send_t         sst;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          seen_busy;

  assign phase          = st;
  assign collect_finish = (st == PROCESS);
  assign frame_done     = (st == DONE);
  assign flt_clear      = (st == DONE);

  // Phase sequencing, pixel pointers, UART handshake and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= COLLECT;
      sst        <= FETCH;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seen_busy  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (rx_valid && (st != COLLECT)) begin
        rx_overrun <= 1'b1;
      end
      case (st)
        COLLECT: begin
          if (rx_valid) begin
            if (wr_ptr == LAST) begin
              wr_ptr <= '0;
              st     <= PROCESS;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        PROCESS: begin
          if (flt_done) begin
            st  <= SEND;
            sst <= FETCH;
          end
        end
        SEND: begin
          case (sst)
            FETCH: sst <= WAIT;
            WAIT:  sst <= ISSUE;
            ISSUE: begin
              if (!tx_busy) begin
                tx_start  <= 1'b1;
                tx_data   <= dst_rdata;
                seen_busy <= 1'b0;
                sst       <= HOLD;
              end
            end
            HOLD: begin
              // A byte is finished only after busy has been seen high and
              // then low again, so a late-rising busy is not mistaken for idle.
              if (tx_busy) begin
                seen_busy <= 1'b1;
              end else if (seen_busy) begin
                seen_busy <= 1'b0;
                sst       <= FETCH;
                if (rd_ptr == LAST) begin
                  rd_ptr <= '0;
                  st     <= DONE;
                end else begin
                  rd_ptr <= rd_ptr + AW'(1);
                end
              end
            end
            default: sst <= FETCH;
          endcase
        end
        DONE:    st <= COLLECT;
        default: st <= COLLECT;
      endcase
    end
  end

  // RAM port steering: each RAM has exactly one write source per phase.
  always_comb begin
    src_addr  = '0;
    src_we    = 1'b0;
    src_wdata = '0;
    dst_addr  = '0;
    dst_we    = 1'b0;
    dst_wdata = '0;
    case (st)
      COLLECT: begin
        src_addr  = wr_ptr;
        // reset holds the phase in COLLECT, so gate the pass-through write
        src_we    = rx_valid & rst_n;
        src_wdata = rx_data;
      end
      PROCESS: begin
        src_addr  = flt_rd_addr;
        dst_addr  = flt_wr_addr;
        dst_we    = flt_wr_en;
        dst_wdata = flt_wr_data;
      end
      SEND: begin
        dst_addr = rd_ptr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_img_frame_sequencer.sv
`timescale 1ns/1ps
module tb_img_frame_sequencer;

  localparam int PIXELS = 4;
  localparam int AW     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [AW-1:0] src_addr;
  logic          src_we;
  logic [7:0]    src_wdata;
  logic [AW-1:0] flt_rd_addr;
  logic [AW-1:0] flt_wr_addr;
  logic          flt_wr_en;
  logic [7:0]    flt_wr_data;
  logic          flt_done;
  logic          collect_finish;
  logic          flt_clear;
  logic [AW-1:0] dst_addr;
  logic          dst_we;
  logic [7:0]    dst_wdata;
  logic [7:0]    dst_rdata;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [1:0]    phase;
  logic          frame_done;
  logic          rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboards: {addr, data} for raw writes, data for UART bytes
  logic [AW+7:0] src_exp_q [$];
  logic [7:0]    tx_exp_q  [$];

  logic [7:0] dst_mem [PIXELS];
  logic [3:0] busy_cnt   = '0;
  logic       busy_force = 1'b0;
  logic       prev_ts    = 1'b0;
  int         tx_cnt     = 0;
  int         tx_base;

  logic [7:0] rx_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  img_frame_sequencer #(.PIXELS(PIXELS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .src_addr(src_addr), .src_we(src_we), .src_wdata(src_wdata),
    .flt_rd_addr(flt_rd_addr), .flt_wr_addr(flt_wr_addr), .flt_wr_en(flt_wr_en),
    .flt_wr_data(flt_wr_data), .flt_done(flt_done),
    .collect_finish(collect_finish), .flt_clear(flt_clear),
    .dst_addr(dst_addr), .dst_we(dst_we), .dst_wdata(dst_wdata), .dst_rdata(dst_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .phase(phase), .frame_done(frame_done), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_phase"}, 32'(phase), 0);
    check({tag, "_cf"}, 32'(collect_finish), 0);
    check({tag, "_clr"}, 32'(flt_clear), 0);
    check({tag, "_txs"}, 32'(tx_start), 0);
    check({tag, "_txd"}, 32'(tx_data), 0);
    check({tag, "_fd"}, 32'(frame_done), 0);
    check({tag, "_ovr"}, 32'(rx_overrun), 0);
    check({tag, "_src_we"}, 32'(src_we), 0);
    check({tag, "_dst_we"}, 32'(dst_we), 0);
  endtask

  // result RAM: one-cycle read latency
  always @(posedge clk) begin
    if (dst_we) dst_mem[dst_addr] <= dst_wdata;
    dst_rdata <= dst_mem[dst_addr];
  end

  // UART transmitter: busy rises the cycle after tx_start and lasts 10 cycles
  always @(posedge clk) begin
    if (tx_start && busy_cnt == 0) busy_cnt <= 4'd10;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  // output monitor
  always @(negedge clk) begin
    if (src_we) begin
      check("src_wr_expected", 32'(src_exp_q.size() != 0), 1);
      if (src_exp_q.size() != 0) begin
        check("src_addr", 32'(src_addr), 32'(src_exp_q[0][AW+7:8]));
        check("src_wdata", 32'(src_wdata), 32'(src_exp_q[0][7:0]));
        void'(src_exp_q.pop_front());
      end
    end
    if (tx_start) begin
      tx_cnt <= tx_cnt + 1;
      check("tx_gap", 32'(prev_ts), 0);
      check("tx_expected", 32'(tx_exp_q.size() != 0), 1);
      if (tx_exp_q.size() != 0) begin
        check("tx_data", 32'(tx_data), 32'(tx_exp_q[0]));
        void'(tx_exp_q.pop_front());
      end
    end
    if (phase == 2'd2) check("send_dst_we", 32'(dst_we), 0);
    prev_ts <= tx_start;
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
    flt_rd_addr = '0; flt_wr_addr = '0; flt_wr_en = 1'b0; flt_wr_data = '0; flt_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1; rx_valid = 1'b0;

    // frame 1: collect, flt_done must be ignored here
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = rx_bytes[i]; flt_done = (i == 0);
      src_exp_q.push_back({AW'(i), rx_bytes[i]});
      @(negedge clk);
      check("collect_phase", 32'(phase), 0);
      check("collect_cf", 32'(collect_finish), 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; flt_done = 1'b0;
    @(negedge clk);
    check("proc_phase", 32'(phase), 1);
    check("proc_cf", 32'(collect_finish), 1);
    check("src_q_drained", 32'(src_exp_q.size()), 0);

    // process: pass-through plus an overrun byte
    @(posedge clk); #1;
    flt_rd_addr = 2'd2; flt_wr_en = 1'b1; flt_wr_addr = 2'd3; flt_wr_data = 8'h5A;
    rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge clk);
    check("pt_src_addr", 32'(src_addr), 2);
    check("pt_src_we", 32'(src_we), 0);
    check("pt_dst_we", 32'(dst_we), 1);
    check("pt_dst_addr", 32'(dst_addr), 3);
    check("pt_dst_wdata", 32'(dst_wdata), 32'h5A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0; flt_wr_addr = AW'(i); flt_wr_data = 8'hA0 + 8'(i);
      tx_exp_q.push_back(8'hA0 + 8'(i));
      @(negedge clk);
      check("ovr_sticky", 32'(rx_overrun), 1);
      check("load_dst_addr", 32'(dst_addr), 32'(i));
    end
    @(posedge clk); #1;
    flt_wr_en = 1'b0; flt_done = 1'b1; busy_force = 1'b1;
    @(negedge clk);
    check("done_wait_phase", 32'(phase), 1);
    @(posedge clk); #1;
    flt_done = 1'b0;
    @(negedge clk);
    check("send_phase", 32'(phase), 2);
    check("send_cf", 32'(collect_finish), 0);

    // busy already high on entry to ISSUE
    repeat (6) @(negedge clk);
    check("busy_block", 32'(tx_cnt), 0);
    @(posedge clk); #1;
    busy_force = 1'b0;

    for (int n = 0; n < 400 && !frame_done; n++) @(negedge clk);
    check("frame_done", 32'(frame_done), 1);
    check("done_clear", 32'(flt_clear), 1);
    check("done_phase", 32'(phase), 3);
    check("tx_count", 32'(tx_cnt), 4);
    check("tx_q_drained", 32'(tx_exp_q.size()), 0);
    @(negedge clk);
    check("post_fd", 32'(frame_done), 0);
    check("post_clear", 32'(flt_clear), 0);
    check("post_phase", 32'(phase), 0);
    check("post_ovr", 32'(rx_overrun), 1);

    // frame 2: reset during SEND with rd_ptr=2
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'h01 + 8'(i);
      src_exp_q.push_back({AW'(i), 8'h01 + 8'(i)});
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; flt_done = 1'b1;
    for (int i = 0; i < 4; i++) tx_exp_q.push_back(8'hA0 + 8'(i));
    tx_base = tx_cnt;
    @(posedge clk); #1;
    flt_done = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 200 && !(phase == 2'd2 && dst_addr == 2'd2); n++) @(negedge clk);
    check("reach_rd2", 32'(dst_addr), 2);
    check("reach_rd2_tx", 32'(tx_cnt - tx_base), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tx_exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h77;
    src_exp_q.push_back({AW'(0), 8'h77});
    @(negedge clk);
    check("restart_src_we", 32'(src_we), 1);
    check("restart_src_addr", 32'(src_addr), 0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("restart_q_drained", 32'(src_exp_q.size()), 0);
    check("restart_phase", 32'(phase), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/img_frame_sequencer.md
IMG_FRAME_SEQUENCER -- requirements
Module: img_frame_sequencer

Interface
REQ-001 SHALL have parameter PIXELS, default 10000: pixels per frame (100x100 image).
REQ-002 SHALL have parameter AW, default 14: RAM address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports rx_valid (input, 1) and rx_data (input, 8): received UART byte, valid for one cycle.
REQ-006 SHALL have ports src_addr (output, AW), src_we (output, 1) and src_wdata (output, 8): the raw-image RAM port.
REQ-007 SHALL have ports flt_rd_addr (input, AW), flt_wr_addr (input, AW), flt_wr_en (input, 1), flt_wr_data (input, 8) and flt_done (input, 1): from the blur filter.
REQ-008 SHALL have ports collect_finish (output, 1) and flt_clear (output, 1): filter start level and one-cycle filter re-arm pulse.
REQ-009 SHALL have ports dst_addr (output, AW), dst_we (output, 1), dst_wdata (output, 8) and dst_rdata (input, 8): the result RAM port, read latency 1.
REQ-010 SHALL have ports tx_start (output, 1), tx_data (output, 8) and tx_busy (input, 1): the UART transmitter.
REQ-011 SHALL have ports phase (output, 2), frame_done (output, 1) and rx_overrun (output, 1): status outputs.

Function
REQ-012 SHALL use phase encoding COLLECT=0, PROCESS=1, SEND=2, DONE=3.
REQ-013 In COLLECT, SHALL forward each rx_valid byte to the raw RAM: src_we=1, src_addr=wr_ptr, src_wdata=rx_data, same cycle (combinational).
REQ-014 SHALL increment wr_ptr after each write.
REQ-015 SHALL leave COLLECT for PROCESS on the write at wr_ptr=PIXELS-1, and SHALL reset wr_ptr to 0 at that point.
REQ-016 SHALL hold collect_finish=1 for the whole of PROCESS and 0 in every other phase.
REQ-017 In PROCESS, SHALL drive src_addr=flt_rd_addr with src_we=0.
REQ-018 In PROCESS, SHALL pass flt_wr_addr, flt_wr_en and flt_wr_data through to dst_addr, dst_we and dst_wdata.
REQ-019 SHALL move PROCESS->SEND on the first cycle that flt_done=1.
REQ-020 SHALL ignore flt_done in every phase other than PROCESS.
REQ-021 In SEND, SHALL run the sub-states FETCH, WAIT, ISSUE, HOLD:
  - FETCH: dst_addr=rd_ptr.
  - WAIT: one cycle for RAM latency.
  - ISSUE: when tx_busy=0, register tx_data=dst_rdata and pulse tx_start for exactly one cycle; while tx_busy=1, stay in ISSUE.
  - HOLD: wait for tx_busy=1 then tx_busy=0, then rd_ptr++ and go to FETCH.
REQ-022 After the HOLD for rd_ptr=PIXELS-1, SHALL go to DONE and reset rd_ptr to 0.
REQ-023 SHALL keep dst_we=0 in SEND.
REQ-024 In SEND, SHALL keep dst_addr stable from FETCH through HOLD.
REQ-025 DONE SHALL last exactly one cycle, pulse frame_done=1 and flt_clear=1, then go to COLLECT.
REQ-026 SHALL drop rx_valid bytes that arrive outside COLLECT (no RAM write) and set rx_overrun=1.
REQ-027 rx_overrun SHALL be sticky until reset.
REQ-028 SHALL hold src_we=0 and dst_we=0 when there is no write source, so neither RAM is ever written by two sources.
REQ-029 SHALL size wr_ptr and rd_ptr at AW bits; the terminal count PIXELS-1 is compared exactly, with no modulo wrap beyond it.
REQ-030 tx_start SHALL never be asserted on two consecutive cycles.

Reset
REQ-031 While rst_n=0, SHALL hold phase=COLLECT and wr_ptr=rd_ptr=0.
REQ-032 While rst_n=0, SHALL hold collect_finish, flt_clear, tx_start, frame_done, rx_overrun, src_we and dst_we at 0.
REQ-033 While rst_n=0, SHALL hold tx_data=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately, asynchronously.
REQ-035 After rst_n rises, SHALL restart from COLLECT with address 0 on the first clock edge.

Verification (PIXELS=4, AW=2 unless noted)
REQ-036 Bench SHALL cover: four rx_valid bytes 0x11,0x22,0x33,0x44 -> src writes at addr 0..3, phase=1 and collect_finish=1 on the cycle after the fourth write.
REQ-037 Bench SHALL cover: in PROCESS, flt_rd_addr=2, flt_wr_en=1, flt_wr_addr=3, flt_wr_data=0x5A -> src_addr=2, dst_we=1, dst_addr=3, dst_wdata=0x5A the same cycle; then flt_done=1 -> phase=2 next cycle.
REQ-038 Bench SHALL cover: result RAM holds A0..A3, tx_busy goes high 1 cycle after each tx_start and lasts 10 cycles -> exactly four tx_start pulses, tx_data A0,A1,A2,A3 in order, then one cycle with frame_done=1 and flt_clear=1, then phase=0.
REQ-039 Bench SHALL cover: tx_busy=1 already on entry to ISSUE -> no tx_start until tx_busy=0.
REQ-040 Bench SHALL cover: rx_valid pulse during PROCESS -> no src write, rx_overrun=1 until reset.
REQ-041 Bench SHALL cover: rst_n=0 during SEND with rd_ptr=2 -> all outputs at reset values immediately; after release, next rx byte is written to addr 0.
